// File: rtl/conversor_pkg.sv
// conversor_pkg: shared seven-segment types and patterns, bit order {g,f,e,d,c,b,a}
package conversor_pkg;
  localparam int SEG_W = 7;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/conversor_4bits_0a9_if.sv
// conversor_4bits_0a9_if: digit inputs and segment outputs; blink exists only with CONVERSOR_BLINK_EN
interface conversor_4bits_0a9_if;
  logic ain, bin, cin, din, en;
  logic aout, bout, cout, dout, eout, fout, gout, err;
`ifdef CONVERSOR_BLINK_EN
  logic blink;
  modport master(output ain, bin, cin, din, en, blink, input aout, bout, cout, dout, eout, fout, gout, err);
  modport slave(input ain, bin, cin, din, en, blink, output aout, bout, cout, dout, eout, fout, gout, err);
`else
  modport master(output ain, bin, cin, din, en, input aout, bout, cout, dout, eout, fout, gout, err);
  modport slave(input ain, bin, cin, din, en, output aout, bout, cout, dout, eout, fout, gout, err);
`endif
endinterface

// File: rtl/bcd7_decode.sv
// bcd7_decode: combinational BCD digit to segment pattern, codes above 9 show a dash
module bcd7_decode
  import conversor_pkg::*;
(
  input  logic [3:0] v,
  output seg_t       pattern,
  output logic       invalid
);
  always_comb begin
    pattern = SEG_DASH;
    case (v)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end
  assign invalid = v > 4'd9;
endmodule

// File: rtl/conversor_4bits_0a9.sv
// conversor_4bits_0a9: registered BCD to seven-segment digit with enable gating
// and an optional blink phase compiled in by CONVERSOR_BLINK_EN.
module conversor_4bits_0a9
  import conversor_pkg::*;
#(
  parameter int BLINK_HALF_PERIOD = 250
) (
  input logic               clk,
  input logic               rst_n,
  conversor_4bits_0a9_if.slave bus
);
  seg_t pattern, seg_d, seg_q;
  logic invalid, err_q, vis;
  bcd7_decode u_dec (
    .v({bus.din, bus.cin, bus.bin, bus.ain}),
    .pattern(pattern),
    .invalid(invalid)
  );
`ifdef CONVERSOR_BLINK_EN
  localparam int CW = $clog2(BLINK_HALF_PERIOD) + 1;
  logic [CW-1:0] cnt;
  logic phase, run;
  assign run = bus.blink & bus.en;
  // visibility is forced on the same edge blink drops, not one phase later
  assign vis = !run || phase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(BLINK_HALF_PERIOD - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign vis = 1'b1;
`endif
  assign seg_d = bus.en && vis ? pattern : SEG_BLANK;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      err_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      err_q <= bus.en & invalid;
    end
  end
  assign {bus.gout, bus.fout, bus.eout, bus.dout, bus.cout, bus.bout, bus.aout} = seg_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_conversor_4bits_0a9.sv
// tb_conversor_4bits_0a9: scoreboard bench with a cycle-level reference model
module tb_conversor_4bits_0a9;
  localparam int HP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  conversor_4bits_0a9_if bus();
  conversor_4bits_0a9 #(.BLINK_HALF_PERIOD(HP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [6:0] tbl [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
  logic [7:0] q [$];
  int total = 0;
  int bad = 0;
  int k = 0;
  function automatic logic [7:0] dut_out();
    return {bus.gout, bus.fout, bus.eout, bus.dout, bus.cout, bus.bout, bus.aout, bus.err};
  endfunction
  function automatic void check(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got seg=%b err=%b, want seg=%b err=%b", name, $time, act[7:1], act[0], req[7:1], req[0]);
    end
  endfunction
  function automatic logic blink_req();
`ifdef CONVERSOR_BLINK_EN
    return bus.blink & bus.en;
`else
    return 1'b0;
`endif
  endfunction
  // k counts consecutive edges with blink active; halves alternate every HP edges
  always @(posedge clk) begin
    if (!rst_n) k = 0;
    else begin
      logic [3:0] v;
      logic [6:0] s;
      logic e;
      v = {bus.din, bus.cin, bus.bin, bus.ain};
      e = bus.en && v > 4'd9;
      s = !bus.en ? 7'h00 : (v > 4'd9 ? 7'h40 : tbl[v]);
      if (blink_req() && ((k / HP) % 2 == 1)) s = 7'h00;
      q.push_back({s, e});
      k = blink_req() ? k + 1 : 0;
    end
  end
  always @(negedge clk) if (q.size() != 0) check("edge", dut_out(), q.pop_front());
  task automatic drive(input logic [3:0] v, input logic en, input logic bl);
    {bus.din, bus.cin, bus.bin, bus.ain} = v;
    bus.en = en;
`ifdef CONVERSOR_BLINK_EN
    bus.blink = bl;
`endif
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    drive(4'd8, 1'b1, 1'b0);
    #1 check("reset_hold", dut_out(), 8'h00);
    #2 check("reset_hold2", dut_out(), 8'h00);
    step(1);
    rst_n = 1'b1;
    step(2);
    for (int v = 0; v < 16; v++) begin
      drive(4'(v), 1'b1, 1'b0);
      step(1);
    end
    drive(4'd12, 1'b0, 1'b0);
    step(2);
    drive(4'd7, 1'b0, 1'b0);
    step(1);
    drive(4'd5, 1'b1, 1'b0);
    step(2);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), 8'h00);
    step(2);
    rst_n = 1'b1;
    step(3);
`ifdef CONVERSOR_BLINK_EN
    drive(4'd3, 1'b1, 1'b1);
    step(HP + 2);
    drive(4'd3, 1'b1, 1'b0);
    step(2);
    drive(4'd3, 1'b1, 1'b1);
    step(HP + 2);
    drive(4'd3, 1'b0, 1'b1);
    step(2);
    drive(4'd12, 1'b1, 1'b1);
    step(3 * HP);
    drive(4'd6, 1'b1, 1'b1);
    step(3 * HP);
`endif
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0);
      step(1);
    end
    drive(4'd0, 1'b0, 1'b0);
    step(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
